// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, funct codes,
// FSM states, ALUOp / ALU control codes and datapath mux selects.
package mips_ctrl_pkg;

    localparam int OP_W     = 6;
    localparam int ALUCTL_W = 3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// ALU control decode from ALUOp and funct; unknown funct falls back to add.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  aluop_t      ALUOp_i,
    input  logic [5:0]  Funct_i,
    output logic [2:0]  ALU_Control_o
);

    always_comb begin
        ALU_Control_o = ALU_ADD;
        case (ALUOp_i)
            ALUOP_SUB: ALU_Control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (Funct_i)
                    FN_SUB:  ALU_Control_o = ALU_SUB;
                    FN_AND:  ALU_Control_o = ALU_AND;
                    FN_OR:   ALU_Control_o = ALU_OR;
                    FN_SLT:  ALU_Control_o = ALU_SLT;
                    default: ALU_Control_o = ALU_ADD;
                endcase
            end
            default: ALU_Control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main Moore control FSM of the multicycle MIPS datapath; outputs decode from
// state only, except PC_En_o (Zero_i) and ALU_Control_o (Funct_i).
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W     = 6,
    parameter int ALUCTL_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     Opcode_i,
    input  logic [OP_W-1:0]     Funct_i,
    input  logic                Zero_i,
    output logic                PC_En_o,
    output logic                IorD_o,
    output logic                Mem_Write_o,
    output logic                IR_Write_o,
    output logic                Reg_Dst_o,
    output logic                Mem_to_Reg_o,
    output logic                Reg_Write_o,
    output logic                ALU_Src_A_o,
    output logic [1:0]          ALU_Src_B_o,
    output logic [1:0]          PC_Src_o,
    output logic [ALUCTL_W-1:0] ALU_Control_o,
    output logic                Illegal_Op_o,
    output logic [3:0]          State_o
);

    state_t r_state;
    state_t w_next;
    logic   r_illegal;
    logic   w_illegal_dec;
    logic   w_pc_write, w_branch, w_ir_write, w_mem_write, w_reg_write;
    aluop_t w_aluop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= r_illegal | w_illegal_dec;
        end
    end

    always_comb begin
        w_next        = S_FETCH;
        w_illegal_dec = 1'b0;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (Opcode_i)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTYPEEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JEX;
                    default: begin
                        w_next        = S_FETCH;
                        w_illegal_dec = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  w_next = (Opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next = S_MEMWB;
            S_RTYPEEX: w_next = S_RTYPEWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            default:   w_next = S_FETCH;
        endcase
    end

    // Unlisted and unreachable states fall through to the FETCH decode.
    always_comb begin
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        IorD_o       = 1'b0;
        Reg_Dst_o    = 1'b0;
        Mem_to_Reg_o = 1'b0;
        ALU_Src_A_o  = 1'b0;
        ALU_Src_B_o  = SRCB_B;
        PC_Src_o     = PCSRC_ALU;
        w_aluop      = ALUOP_ADD;
        case (r_state)
            S_DECODE:  ALU_Src_B_o = SRCB_IMMSH;
            S_MEMADR: begin
                ALU_Src_A_o = 1'b1;
                ALU_Src_B_o = SRCB_IMM;
            end
            S_MEMRD:   IorD_o = 1'b1;
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                Mem_to_Reg_o = 1'b1;
            end
            S_MEMWR: begin
                IorD_o      = 1'b1;
                w_mem_write = 1'b1;
            end
            S_RTYPEEX: begin
                ALU_Src_A_o = 1'b1;
                w_aluop     = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                w_reg_write = 1'b1;
                Reg_Dst_o   = 1'b1;
            end
            S_BEQEX: begin
                ALU_Src_A_o = 1'b1;
                w_aluop     = ALUOP_SUB;
                w_branch    = 1'b1;
                PC_Src_o    = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                ALU_Src_A_o = 1'b1;
                ALU_Src_B_o = SRCB_IMM;
            end
            S_ADDIWB:  w_reg_write = 1'b1;
            S_JEX: begin
                w_pc_write = 1'b1;
                PC_Src_o   = PCSRC_JUMP;
            end
            default: begin
                w_ir_write  = 1'b1;
                w_pc_write  = 1'b1;
                ALU_Src_B_o = SRCB_FOUR;
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .ALUOp_i       (w_aluop),
        .Funct_i       (Funct_i),
        .ALU_Control_o (ALU_Control_o)
    );

    // Architectural write enables are held off while reset is asserted.
    assign PC_En_o      = ~reset & (w_pc_write | (w_branch & Zero_i));
    assign IR_Write_o   = ~reset & w_ir_write;
    assign Mem_Write_o  = ~reset & w_mem_write;
    assign Reg_Write_o  = ~reset & w_reg_write;
    assign Illegal_Op_o = r_illegal;
    assign State_o      = r_state;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Main control FSM of the multicycle MIPS datapath, directly upstream of the register file.
- Sequences each instruction through fetch/decode/execute/memory/writeback.
- Drives Reg_Write_o, plus the register-destination and write-data select lines feeding the register file's write port.
- Drives all other datapath enables and mux selects.
- Contains an ALU decoder producing the 3-bit ALU control from ALUOp and funct.

Parameters:
- OP_W, 6, opcode and funct width (fixed by ISA; not intended to change).
- ALUCTL_W, 3, ALU control width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Opcode_i  input  6  instr[31:26] from instruction register.
- Funct_i  input  6  instr[5:0].
- Zero_i  input  1  ALU zero flag.
- PC_En_o  output  1  PC load enable = PC_Write | (Branch & Zero_i).
- IorD_o  output  1  memory address select: 0 = PC, 1 = ALUOut.
- Mem_Write_o  output  1  memory write enable.
- IR_Write_o  output  1  instruction register load.
- Reg_Dst_o  output  1  write register select: 0 = rt, 1 = rd.
- Mem_to_Reg_o  output  1  write data select: 0 = ALUOut, 1 = MDR.
- Reg_Write_o  output  1  register file write enable.
- ALU_Src_A_o  output  1  0 = PC, 1 = A.
- ALU_Src_B_o  output  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- PC_Src_o  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- ALU_Control_o  output  3  ALU operation code.
- Illegal_Op_o  output  1  sticky flag: unsupported opcode decoded.
- State_o  output  4  current state encoding, for debug.

Behaviour:
- Moore FSM, one state register, 4 bits. Outputs are a combinational decode of the state only.
  - Exception: PC_En_o also uses Zero_i.
  - ALU_Control_o also uses Funct_i.
- Encodings:
  - States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
  - Codes 12-15 are unreachable. They decode as FETCH outputs and go to FETCH next cycle.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: 0x23/0x2B -> MEMADR; 0x00 -> RTYPEEX; 0x04 -> BEQEX; 0x08 -> ADDIEX; 0x02 -> JEX; any other -> FETCH and set Illegal_Op_o.
  - MEMADR: 0x23 -> MEMRD, else MEMWR.
  - MEMRD -> MEMWB.
  - RTYPEEX -> RTYPEWB.
  - ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, JEX -> FETCH.
- Asserted outputs per state (all unlisted outputs are 0):
  - FETCH: IR_Write, PC_Write, ALU_Src_B=01, ALUOp=00.
  - DECODE: ALU_Src_B=11, ALUOp=00.
  - MEMADR: ALU_Src_A=1, ALU_Src_B=10, ALUOp=00.
  - MEMRD: IorD=1.
  - MEMWB: Reg_Write, Mem_to_Reg=1, Reg_Dst=0.
  - MEMWR: IorD=1, Mem_Write.
  - RTYPEEX: ALU_Src_A=1, ALU_Src_B=00, ALUOp=10.
  - RTYPEWB: Reg_Write, Reg_Dst=1, Mem_to_Reg=0.
  - BEQEX: ALU_Src_A=1, ALU_Src_B=00, ALUOp=01, Branch, PC_Src=01.
  - ADDIEX: ALU_Src_A=1, ALU_Src_B=10, ALUOp=00.
  - ADDIWB: Reg_Write, Reg_Dst=0, Mem_to_Reg=0.
  - JEX: PC_Write, PC_Src=10.
- Instruction latency, FETCH to FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- ALU decoder:
  - ALUOp 00 -> 010 (add); ALUOp 01 -> 110 (sub).
  - ALUOp 10 decodes funct: 0x20 -> 010, 0x22 -> 110, 0x24 -> 000, 0x25 -> 001, 0x2A -> 111, other funct -> 010.
  - ALUOp 11 -> 010.
- Reset:
  - Asynchronous assertion forces the state to FETCH and clears Illegal_Op_o.
  - While reset is high, PC_En_o, IR_Write_o, Mem_Write_o and Reg_Write_o are forced 0 combinationally. Other outputs show FETCH decode.
  - The first FETCH write-enables appear in the first cycle after reset deasserts.
  - Reset mid-instruction abandons the instruction; no partial writeback occurs.
- Illegal_Op_o is set on the clock edge leaving DECODE with an illegal opcode. It stays 1 until reset; execution continues.
- BEQEX: PC_En_o = Zero_i in that cycle.
- No other state writes more than one architectural element per cycle.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - funct constants;
  - state encodings;
  - ALUOp and ALU control codes;
  - ALU_Src_B and PC_Src encodings.
- One sub-module, alu_decoder: combinational, inputs ALUOp[1:0] and Funct[5:0], output ALU_Control[2:0].
- The FSM (state register, next-state logic, output decode) stays in multicycle_control_unit.

Test Plan:
- Reset held 3 cycles, then released, Opcode_i=0x23 -> State_o sequence 0,1,2,3,4,0.
  - Reg_Write_o=1 with Mem_to_Reg_o=1 only in state 4.
  - Write-enables are 0 throughout reset.
- Opcode_i=0x00, Funct_i=0x2A -> states 0,1,6,7,0.
  - ALU_Control_o=111 in state 6.
  - Reg_Write_o=1 with Reg_Dst_o=1 in state 7.
- Opcode_i=0x04 -> states 0,1,8. In state 8:
  - Zero_i=1 -> PC_En_o=1 and PC_Src_o=01.
  - Zero_i=0 -> PC_En_o=0.
- Opcode_i=0x2B -> states 0,1,2,5,0. Mem_Write_o=1 and IorD_o=1 only in state 5; Reg_Write_o never asserted.
- Opcode_i=0x3F -> states 0,1,0 and Illegal_Op_o rises after DECODE. It stays 1 through a following 0x02 jump (states 0,1,11,0, PC_Src_o=10) until reset.
- Reset asserted during state 3 of a lw -> State_o=0 immediately (asynchronous) and Reg_Write_o stays 0. Normal fetch resumes after release.
